dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 38 +++
 rtl/dmem_arbiter_arb_pick.sv | 16 +
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Holds the FSM state enum, the port-id type and the RISC-V funct3 codes
// used by loads and stores.
package dmem_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Port 0 = core, port 1 = DMA/debug
  typedef logic port_id_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports and the memory-stage
// connection of the arbiter. The master side is whoever drives requests and
// returns memory read data; the slave side is the arbiter itself.
interface dmem_arbiter_if #(
  parameter int N = 32
);
  // Requester side
  logic [1:0]   req;
  logic [1:0]   we;
  logic [N-1:0] addr0;
  logic [N-1:0] addr1;
  logic [N-1:0] wdata0;
  logic [N-1:0] wdata1;
  logic [2:0]   fn3_0;
  logic [2:0]   fn3_1;
  logic [1:0]   gnt;
  logic [1:0]   rvalid;
  logic [N-1:0] rdata;

  // Memory-stage side
  logic [N-1:0] alu_out;
  logic [N-1:0] data_in;
  logic         mem_read;
  logic         mem_write;
  logic [2:0]   fn3;
  logic [N-1:0] mem_out;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, fn3_0, fn3_1, mem_out,
    input  gnt, rvalid, rdata, alu_out, data_in, mem_read, mem_write, fn3
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, fn3_0, fn3_1, mem_out,
    output gnt, rvalid, rdata, alu_out, data_in, mem_read, mem_write, fn3
  );

endinterface

// File: rtl/dmem_arbiter_arb_pick.sv
// arb_pick: two-port winner selection. A lone requester always wins; on
// contention the port that is NOT named by ptr wins. Feeding ptr with the
// last-granted port gives round-robin, tying it to 1 gives port-0 priority.
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   ptr,
  output logic [1:0] grant
);

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_pick
    assign grant[gi] = req[gi] & (~req[NUM_PORTS-1-gi] | (ptr != port_id_t'(gi)));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates two requesters onto one memory stage.
// Each transaction is grant (IDLE) -> one memory access cycle (ACCESS) ->
// one response cycle (RESP). Define DMEM_ARB_RR_EN for round-robin
// arbitration; without it port 0 has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  state_t       state_reg, state_next;
  logic         we_reg;
  logic [N-1:0] addr_reg;
  logic [N-1:0] wdata_reg;
  logic [2:0]   fn3_reg;
  port_id_t     port_reg;
  logic [N-1:0] rdata_reg;
  logic [1:0]   pick;
  logic         grant_fire;
  port_id_t     ptr;

  assign grant_fire = (state_reg == IDLE) && (|pick);

`ifdef DMEM_ARB_RR_EN
  port_id_t ptr_reg;

  // Remember the last-granted port so the other one wins the next contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ptr_reg <= 1'b0;
    else if (grant_fire) ptr_reg <= pick[1];
  end

  assign ptr = ptr_reg;
`else
  // Pretend port 1 was last served so port 0 always wins contention
  assign ptr = 1'b1;
`endif

  arb_pick u_arb_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .grant(pick)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Latch the winner's payload at grant; later payload changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      fn3_reg   <= '0;
      port_reg  <= 1'b0;
    end else if (grant_fire) begin
      port_reg  <= pick[1];
      we_reg    <= pick[1] ? bus.we[1] : bus.we[0];
      addr_reg  <= pick[1] ? bus.addr1  : bus.addr0;
      wdata_reg <= pick[1] ? bus.wdata1 : bus.wdata0;
      fn3_reg   <= pick[1] ? bus.fn3_1  : bus.fn3_0;
    end
  end

  // Capture load data during the access; stores respond with zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rdata_reg <= '0;
    else if (state_reg == ACCESS) rdata_reg <= we_reg ? '0 : bus.mem_out;
  end

  assign bus.rdata = rdata_reg;

  // Next-state and output decode; everything defaults to zero
  always_comb begin
    state_next    = state_reg;
    bus.gnt       = 2'b00;
    bus.rvalid    = 2'b00;
    bus.alu_out   = '0;
    bus.data_in   = '0;
    bus.fn3       = 3'b000;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    case (state_reg)
      IDLE: begin
        // Grant is combinational, so mask it while reset is held
        bus.gnt = pick & {2{rst_n}};
        if (|pick) state_next = ACCESS;
      end
      ACCESS: begin
        bus.alu_out   = addr_reg;
        bus.data_in   = wdata_reg;
        bus.fn3       = fn3_reg;
        bus.mem_read  = ~we_reg;
        bus.mem_write = we_reg;
        state_next    = RESP;
      end
      RESP: begin
        bus.rvalid = 2'b01 << port_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int N = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  dmem_arbiter_if #(.N(N)) bus ();

  dmem_arbiter #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Arbitration rule: lone requester wins; contention resolved by policy
  function automatic logic [1:0] policy(input logic [1:0] r, input logic last);
    if (r == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      return last ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    return r;
  endfunction

  // ---------------- reference model (transaction schedule) ----------------
  int          cyc;
  logic        m_busy;
  int          m_t;
  logic        m_port, m_we, m_last;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_fn3;
  logic [1:0]  exp_gnt_q;
  logic [1:0]  e_gnt, e_rv;
  logic        e_rd, e_wr;
  logic [31:0] e_addr, e_data, rd_new;
  logic [2:0]  e_fn3;

  // Every cycle: derive expected outputs from the transaction schedule
  always @(negedge clk) begin
    e_gnt = 2'b00; e_rv = 2'b00; e_rd = 1'b0; e_wr = 1'b0;
    e_addr = '0; e_data = '0; e_fn3 = '0; rd_new = m_rdata;
    if (!rst_n) begin
      m_busy = 1'b0; m_rdata = '0; rd_new = '0; m_last = 1'b0;
    end else if (!m_busy) begin
      e_gnt = policy(bus.req, m_last);
      if (e_gnt != 2'b00) begin
        m_port  = e_gnt[1];
        m_we    = bus.we[m_port];
        m_addr  = m_port ? bus.addr1  : bus.addr0;
        m_wdata = m_port ? bus.wdata1 : bus.wdata0;
        m_fn3   = m_port ? bus.fn3_1  : bus.fn3_0;
        m_last  = m_port;
        m_t     = cyc;
        m_busy  = 1'b1;
      end
    end else if (cyc == m_t + 1) begin
      e_rd = ~m_we; e_wr = m_we;
      e_addr = m_addr; e_data = m_wdata; e_fn3 = m_fn3;
      rd_new = m_we ? 32'h0 : bus.mem_out;
    end else if (cyc == m_t + 2) begin
      e_rv   = 2'b01 << m_port;
      m_busy = 1'b0;
    end
    check("gnt",       {30'h0, bus.gnt},       {30'h0, e_gnt});
    check("rvalid",    {30'h0, bus.rvalid},    {30'h0, e_rv});
    check("rdata",     bus.rdata,              m_rdata);
    check("mem_read",  {31'h0, bus.mem_read},  {31'h0, e_rd});
    check("mem_write", {31'h0, bus.mem_write}, {31'h0, e_wr});
    check("alu_out",   bus.alu_out,            e_addr);
    check("data_in",   bus.data_in,            e_data);
    check("fn3",       {29'h0, bus.fn3},       {29'h0, e_fn3});
    m_rdata   = rd_new;
    exp_gnt_q = e_gnt;
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [2:0] f0, input logic [2:0] f1);
    bus.req = r; bus.we = w; bus.addr0 = a0; bus.addr1 = a1;
    bus.wdata0 = d0; bus.wdata1 = d1; bus.fn3_0 = f0; bus.fn3_1 = f1;
  endtask

  task automatic rand_payload(input int p);
    if (p == 0) begin
      bus.we[0] = 1'($urandom); bus.addr0 = $urandom; bus.wdata0 = $urandom; bus.fn3_0 = 3'($urandom);
    end else begin
      bus.we[1] = 1'($urandom); bus.addr1 = $urandom; bus.wdata1 = $urandom; bus.fn3_1 = 3'($urandom);
    end
  endtask

  logic [1:0] seq [3];

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    m_busy = 1'b0; m_t = 0; m_rdata = '0; m_last = 1'b0; m_port = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_fn3 = '0; exp_gnt_q = 2'b00;
    rst_n = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 3'b000, 3'b000);
    bus.mem_out = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_gnt",    {30'h0, bus.gnt},    32'h0);
    check("rst_rvalid", {30'h0, bus.rvalid}, 32'h0);
    check("rst_rdata",  bus.rdata,           32'h0);
    check("rst_strobe", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    repeat (2) next_cycle();
    rst_n = 1'b1;

    // Reset during ACCESS aborts the port-0 load
    drive(2'b01, 2'b00, 32'h40, 0, 0, 0, LW, LW);
    bus.mem_out = 32'h1234_5678;
    @(negedge clk); check("rma_gnt", {30'h0, bus.gnt}, 32'h1);
    next_cycle();
    bus.req = 2'b00;
    rst_n = 1'b0;
    #1;
    check("rma_async_rd",  {31'h0, bus.mem_read}, 32'h0);
    check("rma_async_adr", bus.alu_out, 32'h0);
    @(negedge clk);
    check("rma_rvalid", {30'h0, bus.rvalid}, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rma_norv", {30'h0, bus.rvalid}, 32'h0);
    check("rma_rdata", bus.rdata, 32'h0);
    next_cycle();

    // Single load on port 0
    drive(2'b01, 2'b00, 32'h10, 0, 0, 0, LW, LW);
    bus.mem_out = 32'hDEAD_BEEF;
    @(negedge clk); check("ld_gnt", {30'h0, bus.gnt}, 32'h1);
    next_cycle(); bus.req = 2'b00;
    @(negedge clk); check("ld_mem_read", {31'h0, bus.mem_read}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("ld_rvalid", {30'h0, bus.rvalid}, 32'h1);
    check("ld_rdata",  bus.rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Single store on port 1
    drive(2'b10, 2'b10, 0, 32'h20, 0, 32'h0000_00AB, LW, SB);
    @(negedge clk); check("st_gnt", {30'h0, bus.gnt}, 32'h2);
    next_cycle(); bus.req = 2'b00;
    @(negedge clk);
    check("st_mem_write", {31'h0, bus.mem_write}, 32'h1);
    check("st_alu_out",   bus.alu_out, 32'h20);
    check("st_data_in",   bus.data_in, 32'hAB);
    check("st_fn3",       {29'h0, bus.fn3}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("st_rvalid", {30'h0, bus.rvalid}, 32'h2);
    check("st_rdata",  bus.rdata, 32'h0);
    next_cycle();

    // Contention with both requests held (last grant went to port 1)
`ifdef DMEM_ARB_RR_EN
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01;
`else
    seq[0] = 2'b01; seq[1] = 2'b01; seq[2] = 2'b01;
`endif
    drive(2'b11, 2'b00, 32'h100, 32'h200, 0, 0, LW, LH);
    bus.mem_out = 32'h5555_AAAA;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k % 3 == 0) check($sformatf("cont_gnt%0d", k / 3), {30'h0, bus.gnt}, {30'h0, seq[k / 3]});
      next_cycle();
    end
    bus.req = 2'b10;
    @(negedge clk); check("cont_p1_after_drop", {30'h0, bus.gnt}, 32'h2);
    next_cycle(); bus.req = 2'b00;
    next_cycle(); next_cycle();

    // Withdrawal: port 1 pulses req during port 0 ACCESS, then drops it
    drive(2'b01, 2'b00, 32'h44, 32'h88, 0, 0, LW, LW);
    @(negedge clk); check("wd_gnt0", {30'h0, bus.gnt}, 32'h1);
    next_cycle(); bus.req = 2'b11;
    @(negedge clk); check("wd_gnt_access", {30'h0, bus.gnt}, 32'h0);
    next_cycle(); bus.req = 2'b00;
    @(negedge clk); check("wd_rvalid", {30'h0, bus.rvalid}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("wd_no_gnt1",   {30'h0, bus.gnt},    32'h0);
    check("wd_no_rvalid", {30'h0, bus.rvalid}, 32'h0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst_n = ($urandom_range(399) != 0);
      for (int p = 0; p < 2; p++) begin
        if (bus.req[p] && exp_gnt_q[p]) begin
          bus.req[p] = 1'($urandom);
          rand_payload(p);
        end else if (bus.req[p]) begin
          if ($urandom_range(15) == 0) bus.req[p] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          bus.req[p] = 1'b1;
          rand_payload(p);
        end
      end
      bus.mem_out = $urandom;
    end
    next_cycle();
    rst_n = 1'b1;
    bus.req = 2'b00;
    repeat (4) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
